i2c_fifo_buffer: RTL and testbench

- Synchronous byte FIFO on the APB clock domain that sits between the APB register block and the I2C byte engine.
- Used as the TX buffer: the APB write strobe for address 0x00 pushes bytes, and the I2C engine pops them.
- Used as the RX buffer: the I2C engine pushes bytes, and an APB read of address 0x01 pops them.
- Its rd_data_o and status_o drive the register block's FIFO-data input and status input.

---
 rtl/i2c_fifo_buffer.sv | 93 +++++++++
 tb/tb_i2c_fifo_buffer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_fifo_buffer.sv
// Byte FIFO between the APB register block and the I2C byte engine.
// Wrap-bit pointers, registered pop data, sticky overflow/underflow flags.
module i2c_fifo_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int PTR_WIDTH  = 3
) (
  input  logic                  pclk_i,
  input  logic                  preset_ni,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic                  flush_i,
  input  logic                  clr_flags_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [PTR_WIDTH:0]    level_o,
  output logic [7:0]            status_o
);

  localparam int DEPTH = 1 << PTR_WIDTH;
  localparam logic [PTR_WIDTH:0] PTR_ONE   = {{PTR_WIDTH{1'b0}}, 1'b1};
  localparam logic [PTR_WIDTH:0] LVL_AFULL = {1'b0, {PTR_WIDTH{1'b1}}};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH:0]    wptr;
  logic [PTR_WIDTH:0]    rptr;
  logic                  ovf_flag;
  logic                  udf_flag;
  logic                  push_acc;
  logic                  pop_acc;
  logic                  push_rej;
  logic                  pop_rej;
  logic                  almost_empty;
  logic                  almost_full;

  assign empty_o = (wptr == rptr);
  assign full_o  = (wptr[PTR_WIDTH-1:0] == rptr[PTR_WIDTH-1:0]) &&
                   (wptr[PTR_WIDTH] != rptr[PTR_WIDTH]);
  assign level_o = wptr - rptr;

  // Flush swallows both requests, so neither can raise a flag that cycle.
  assign pop_acc  = rd_en_i && !empty_o && !flush_i;
  assign push_acc = wr_en_i && (!full_o || pop_acc) && !flush_i;
  assign push_rej = wr_en_i && !flush_i && !push_acc;
  assign pop_rej  = rd_en_i && !flush_i && empty_o;

  assign almost_empty = (level_o <= PTR_ONE);
  assign almost_full  = (level_o >= LVL_AFULL);
  assign status_o     = {2'b00, udf_flag, ovf_flag, almost_full, almost_empty, full_o, empty_o};

  // Storage is not reset; a push at full reuses the slot being popped.
  always_ff @(posedge pclk_i) begin
    if (push_acc) begin
      mem[wptr[PTR_WIDTH-1:0]] <= wr_data_i;
    end
  end

  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      wptr      <= '0;
      rptr      <= '0;
      rd_data_o <= '0;
      ovf_flag  <= 1'b0;
      udf_flag  <= 1'b0;
    end else begin
      if (flush_i) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (push_acc) begin
          wptr <= wptr + PTR_ONE;
        end
        if (pop_acc) begin
          rptr      <= rptr + PTR_ONE;
          rd_data_o <= mem[rptr[PTR_WIDTH-1:0]];
        end
      end
      // A new event in the same cycle as a clear keeps the flag set.
      if (push_rej) begin
        ovf_flag <= 1'b1;
      end else if (clr_flags_i) begin
        ovf_flag <= 1'b0;
      end
      if (pop_rej) begin
        udf_flag <= 1'b1;
      end else if (clr_flags_i) begin
        udf_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2c_fifo_buffer.sv
// Directed bench for i2c_fifo_buffer: fill/drain, flags, wrap, flush, reset.
module tb_i2c_fifo_buffer;

  logic       pclk_i;
  logic       preset_ni;
  logic       wr_en_i;
  logic [7:0] wr_data_i;
  logic       rd_en_i;
  logic       flush_i;
  logic       clr_flags_i;
  logic [7:0] rd_data_o;
  logic       full_o;
  logic       empty_o;
  logic [3:0] level_o;
  logic [7:0] status_o;

  int n_cmp;
  int n_err;

  i2c_fifo_buffer #(.DATA_WIDTH(8), .PTR_WIDTH(3)) dut (
    .pclk_i      (pclk_i),
    .preset_ni   (preset_ni),
    .wr_en_i     (wr_en_i),
    .wr_data_i   (wr_data_i),
    .rd_en_i     (rd_en_i),
    .flush_i     (flush_i),
    .clr_flags_i (clr_flags_i),
    .rd_data_o   (rd_data_o),
    .full_o      (full_o),
    .empty_o     (empty_o),
    .level_o     (level_o),
    .status_o    (status_o)
  );

  initial pclk_i = 1'b0;
  always #5 pclk_i = ~pclk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge pclk_i);
    #1;
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    preset_ni   = 1'b0;
    wr_en_i     = 1'b0;
    wr_data_i   = 8'h00;
    rd_en_i     = 1'b0;
    flush_i     = 1'b0;
    clr_flags_i = 1'b0;
    tick();
    tick();
    preset_ni = 1'b1;
    tick();

    chk("rst_status", 32'(status_o), 32'h05);
    chk("rst_level", 32'(level_o), 32'h0);
    chk("rst_rdata", 32'(rd_data_o), 32'h00);
    chk("rst_empty", 32'(empty_o), 32'h1);
    chk("rst_full", 32'(full_o), 32'h0);

    for (int i = 0; i < 8; i++) begin
      wr_en_i   = 1'b1;
      wr_data_i = 8'(8'hA1 + i);
      tick();
      chk("fill_level", 32'(level_o), 32'(i + 1));
    end
    wr_en_i = 1'b0;
    chk("fill_full", 32'(full_o), 32'h1);
    chk("fill_status", 32'(status_o), 32'h0A);

    wr_en_i   = 1'b1;
    wr_data_i = 8'hFF;
    tick();
    wr_en_i = 1'b0;
    chk("ovf_level", 32'(level_o), 32'h8);
    chk("ovf_status", 32'(status_o), 32'h1A);
    clr_flags_i = 1'b1;
    tick();
    clr_flags_i = 1'b0;
    chk("clr_status", 32'(status_o), 32'h0A);

    for (int i = 0; i < 8; i++) begin
      rd_en_i = 1'b1;
      tick();
      chk("drain_data", 32'(rd_data_o), 32'hA1 + 32'(i));
    end
    rd_en_i = 1'b0;
    chk("drain_empty", 32'(empty_o), 32'h1);
    chk("drain_level", 32'(level_o), 32'h0);
    chk("drain_status", 32'(status_o), 32'h05);
    tick();
    chk("drain_hold", 32'(rd_data_o), 32'hA8);

    wr_en_i   = 1'b1;
    wr_data_i = 8'h5C;
    rd_en_i   = 1'b1;
    tick();
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
    chk("udf_level", 32'(level_o), 32'h1);
    chk("udf_status", 32'(status_o), 32'h24);
    chk("udf_rdata", 32'(rd_data_o), 32'hA8);
    rd_en_i = 1'b1;
    tick();
    rd_en_i = 1'b0;
    chk("udf_pop", 32'(rd_data_o), 32'h5C);
    chk("udf_pop_status", 32'(status_o), 32'h25);
    clr_flags_i = 1'b1;
    tick();
    clr_flags_i = 1'b0;
    chk("udf_clr", 32'(status_o), 32'h05);

    // Prime three entries, then hold the level at 3 across a pointer wrap.
    for (int i = 0; i < 3; i++) begin
      wr_en_i   = 1'b1;
      wr_data_i = 8'(8'hB0 + i);
      tick();
    end
    for (int k = 0; k < 20; k++) begin
      wr_en_i   = 1'b1;
      wr_data_i = 8'(8'hC0 + k);
      rd_en_i   = 1'b1;
      tick();
      if (k < 3) chk("wrap_data", 32'(rd_data_o), 32'hB0 + 32'(k));
      else       chk("wrap_data", 32'(rd_data_o), 32'hC0 + 32'(k - 3));
      chk("wrap_level", 32'(level_o), 32'h3);
    end
    rd_en_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_en_i   = 1'b1;
      wr_data_i = 8'(8'hE0 + i);
      tick();
    end
    chk("refill_full", 32'(full_o), 32'h1);
    wr_data_i = 8'hF0;
    rd_en_i   = 1'b1;
    tick();
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
    chk("full_rw_data", 32'(rd_data_o), 32'hD1);
    chk("full_rw_level", 32'(level_o), 32'h8);
    chk("full_rw_full", 32'(full_o), 32'h1);
    chk("full_rw_status", 32'(status_o), 32'h0A);
    rd_en_i = 1'b1;
    tick();
    chk("after_full_d2", 32'(rd_data_o), 32'hD2);
    tick();
    chk("after_full_d3", 32'(rd_data_o), 32'hD3);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("after_full_e", 32'(rd_data_o), 32'hE0 + 32'(i));
    end
    tick();
    rd_en_i = 1'b0;
    chk("after_full_f0", 32'(rd_data_o), 32'hF0);
    chk("after_full_empty", 32'(empty_o), 32'h1);

    for (int i = 0; i < 5; i++) begin
      wr_en_i   = 1'b1;
      wr_data_i = 8'(8'h11 + i);
      tick();
    end
    chk("pre_flush_level", 32'(level_o), 32'h5);
    wr_data_i = 8'h99;
    flush_i   = 1'b1;
    tick();
    flush_i = 1'b0;
    wr_en_i = 1'b0;
    chk("flush_level", 32'(level_o), 32'h0);
    chk("flush_empty", 32'(empty_o), 32'h1);
    chk("flush_rdata", 32'(rd_data_o), 32'hF0);
    chk("flush_status", 32'(status_o), 32'h05);
    wr_en_i   = 1'b1;
    wr_data_i = 8'h77;
    tick();
    wr_en_i = 1'b0;
    chk("post_flush_level", 32'(level_o), 32'h1);
    rd_en_i = 1'b1;
    tick();
    rd_en_i = 1'b0;
    chk("post_flush_data", 32'(rd_data_o), 32'h77);

    for (int i = 0; i < 3; i++) begin
      wr_en_i   = 1'b1;
      wr_data_i = 8'(8'h31 + i);
      tick();
    end
    chk("burst_level", 32'(level_o), 32'h3);
    #2;
    preset_ni = 1'b0;
    #1;
    chk("midrst_level", 32'(level_o), 32'h0);
    chk("midrst_empty", 32'(empty_o), 32'h1);
    chk("midrst_full", 32'(full_o), 32'h0);
    chk("midrst_rdata", 32'(rd_data_o), 32'h00);
    chk("midrst_status", 32'(status_o), 32'h05);
    wr_en_i = 1'b0;
    #1;
    preset_ni = 1'b1;
    tick();
    chk("post_rst_level", 32'(level_o), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
